// File: rtl/lopd_rr_arbiter.sv
// Round-robin arbiter in front of one shared leading-one detector.
// Define LOPD_ARB_FAST_EN to skip CALC and detect on the accept edge (1-cycle latency).
module lopd_rr_arbiter #(
  parameter int SIZE_DATA = 24,
  parameter int SIZE_LOPD = 5,
  parameter int NUM_REQ   = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]     o_rsp_id,
  output logic [SIZE_LOPD-1:0]           o_rsp_position,
  output logic                           o_rsp_zero,
  output logic                           o_busy
);

  localparam int SIZE_ID = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t               state_reg, state_next;
  logic [SIZE_ID-1:0]   ptr_reg, ptr_next;
  logic [SIZE_ID-1:0]   rsp_id_reg;
  logic [SIZE_LOPD-1:0] rsp_pos_reg;
  logic                 rsp_zero_reg;

  logic [SIZE_DATA-1:0] req_data_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_data_arr[gi] = i_req_data[gi*SIZE_DATA +: SIZE_DATA];
    end
  endgenerate

  // Round-robin pick: lowest valid index at/above ptr, else lowest valid overall.
  logic [NUM_REQ-1:0] mask_hi, masked_valid, grant_src;
  logic [SIZE_ID-1:0] grant_id;
  logic               grant_any;
  logic               accept;

  always_comb begin
    mask_hi = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask_hi[i] = (i >= int'(ptr_reg));
    end
    masked_valid = i_req_valid & mask_hi;
    grant_src    = (|masked_valid) ? masked_valid : i_req_valid;
    grant_id     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (grant_src[i]) grant_id = SIZE_ID'(i);
    end
  end

  assign grant_any = |i_req_valid;
  assign accept    = (state_reg == IDLE) && grant_any;
  assign ptr_next  = (grant_id == SIZE_ID'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign o_req_ready[gi] = i_rst_n && accept && (grant_id == SIZE_ID'(gi));
    end
  endgenerate

  // Shared detector; its operand source depends on the build variant.
  logic [SIZE_DATA-1:0] det_in;
  logic [SIZE_LOPD-1:0] det_pos;
  logic                 det_zero;

`ifdef LOPD_ARB_FAST_EN
  assign det_in = req_data_arr[grant_id];
`else
  logic [SIZE_DATA-1:0] data_reg;
  logic [SIZE_ID-1:0]   id_reg;
  assign det_in = data_reg;
`endif

  always_comb begin
    det_pos = '0;
    for (int b = 0; b < SIZE_DATA; b++) begin
      if (det_in[b]) det_pos = SIZE_LOPD'(b);
    end
    det_zero = ~|det_in;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_any) begin
`ifdef LOPD_ARB_FAST_EN
          state_next = RESP;
`else
          state_next = CALC;
`endif
        end
      end
      CALC:    state_next = RESP;
      RESP:    if (i_rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      rsp_id_reg   <= '0;
      rsp_pos_reg  <= '0;
      rsp_zero_reg <= 1'b0;
`ifndef LOPD_ARB_FAST_EN
      data_reg     <= '0;
      id_reg       <= '0;
`endif
    end else begin
      state_reg <= state_next;
      if (accept) begin
        ptr_reg <= ptr_next;
`ifdef LOPD_ARB_FAST_EN
        rsp_id_reg   <= grant_id;
        rsp_pos_reg  <= det_pos;
        rsp_zero_reg <= det_zero;
`else
        data_reg <= req_data_arr[grant_id];
        id_reg   <= grant_id;
`endif
      end
`ifndef LOPD_ARB_FAST_EN
      if (state_reg == CALC) begin
        rsp_id_reg   <= id_reg;
        rsp_pos_reg  <= det_pos;
        rsp_zero_reg <= det_zero;
      end
`endif
    end
  end

  assign o_rsp_valid    = (state_reg == RESP);
  assign o_busy         = (state_reg != IDLE);
  assign o_rsp_id       = rsp_id_reg;
  assign o_rsp_position = rsp_pos_reg;
  assign o_rsp_zero     = rsp_zero_reg;

endmodule

// File: tb/tb_lopd_rr_arbiter.sv
// Self-checking bench for lopd_rr_arbiter (default three-state build):
// cycle model compared every cycle plus directed literal expectations.
module tb_lopd_rr_arbiter;

  logic        i_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [95:0] req_data = '0;
  logic [3:0]  o_req_ready;
  logic        o_rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  o_rsp_id;
  logic [4:0]  o_rsp_position;
  logic        o_rsp_zero;
  logic        o_busy;

  int checks = 0;
  int failures = 0;

  lopd_rr_arbiter #(.SIZE_DATA(24), .SIZE_LOPD(5), .NUM_REQ(4)) dut (
    .i_clk(i_clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_data(req_data), .o_req_ready(o_req_ready),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_id(o_rsp_id), .o_rsp_position(o_rsp_position),
    .o_rsp_zero(o_rsp_zero), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Spec-level helpers: round-robin search and floor(log2(x)).
  function automatic int model_grant(input logic [3:0] v, input int p);
    for (int i = 0; i < 4; i++) if (v[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  function automatic int model_lopd(input int x);
    int p = 0;
    int y = x;
    while (y > 1) begin y = y >> 1; p++; end
    return p;
  endfunction

  // Model: idle, or "age" cycles since the accept cycle (1 = computing, 2 = responding).
  bit   m_busy = 0;
  int   m_age = 0, m_ptr = 0, m_pend_id = 0, m_pend_data = 0;
  int   m_id = 0, m_pos = 0, m_zero = 0;

  initial begin : compare
    logic [3:0] exp_ready;
    int g;
    forever begin
      @(negedge i_clk);
      if (!rst_n) begin
        chk("rst_ready", o_req_ready, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_fields", {o_rsp_id, o_rsp_position, o_rsp_zero}, 0);
        m_busy = 0; m_age = 0; m_ptr = 0; m_id = 0; m_pos = 0; m_zero = 0;
        continue;
      end
      exp_ready = '0;
      g = model_grant(req_valid, m_ptr);
      if (!m_busy && g >= 0) exp_ready[g] = 1'b1;
      chk("m_ready", o_req_ready, exp_ready);
      chk("m_rsp_valid", o_rsp_valid, (m_busy && m_age == 2) ? 1 : 0);
      chk("m_busy", o_busy, m_busy ? 1 : 0);
      chk("m_id", o_rsp_id, m_id);
      chk("m_pos", o_rsp_position, m_pos);
      chk("m_zero", o_rsp_zero, m_zero);
      if (!m_busy) begin
        if (g >= 0) begin
          m_pend_id = g;
          m_pend_data = int'(req_data[g*24 +: 24]);
          m_ptr = (g + 1) % 4;
          m_busy = 1; m_age = 1;
        end
      end else if (m_age == 1) begin
        m_age = 2;
        m_id = m_pend_id;
        m_zero = (m_pend_data == 0) ? 1 : 0;
        m_pos = (m_pend_data == 0) ? 0 : model_lopd(m_pend_data);
      end else if (rsp_ready) begin
        m_busy = 0; m_age = 0;
      end
    end
  end

  typedef struct { int id; int pos; int zero; int lat; } rsp_t;
  rsp_t rsp_q[$];
  int cyc = 0, last_acc = 0;

  // One clock: sample accepts/responses at negedge, drop accepted valids after posedge.
  task automatic step();
    logic [3:0] acc;
    rsp_t r;
    @(negedge i_clk);
    cyc++;
    acc = o_req_ready & req_valid;
    if (acc != 0) last_acc = cyc;
    if (rst_n && o_rsp_valid && rsp_ready) begin
      r.id = int'(o_rsp_id); r.pos = int'(o_rsp_position);
      r.zero = int'(o_rsp_zero); r.lat = cyc - last_acc;
      rsp_q.push_back(r);
    end
    @(posedge i_clk); #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic wait_rsps(input int n, input int budget, input string name);
    int b = 0;
    while (rsp_q.size() < n && b < budget) begin step(); b++; end
    chk({name, "_timeout"}, rsp_q.size() >= n, 1);
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {o_req_ready, o_rsp_valid, o_busy, o_rsp_id, o_rsp_position, o_rsp_zero}, 0);
    repeat (2) @(posedge i_clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin : stim
    rsp_t r;
    int exp_pos[4] = '{23, 4, 15, 0};
    int b;
    repeat (3) @(posedge i_clk);
    #1 rst_n = 1'b1;

    // Zero operand on requester 0.
    rsp_q.delete();
    req_data[0 +: 24] = 24'h000000; req_valid[0] = 1'b1;
    wait_rsps(1, 10, "zero");
    if (rsp_q.size() > 0) begin
      r = rsp_q.pop_front();
      chk("zero_id", r.id, 0); chk("zero_pos", r.pos, 0);
      chk("zero_flag", r.zero, 1); chk("zero_latency", r.lat, 2);
    end

    // One-hot sweep on requester 1.
    for (int k = 0; k < 24; k++) begin
      rsp_q.delete();
      req_data[24 +: 24] = 24'(1) << k; req_valid[1] = 1'b1;
      wait_rsps(1, 10, "sweep");
      if (rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        chk($sformatf("sweep%0d_pos", k), r.pos, k);
        chk($sformatf("sweep%0d_id", k), r.id, 1);
        chk($sformatf("sweep%0d_zero", k), r.zero, 0);
        chk($sformatf("sweep%0d_lat", k), r.lat, 2);
      end
    end

    // All four requesters valid after reset: strict rotation 0..3.
    do_reset();
    rsp_q.delete();
    req_data = {24'h000001, 24'h00F000, 24'h000010, 24'h800000};
    req_valid = 4'hF;
    wait_rsps(4, 30, "rr4");
    for (int i = 0; i < 4 && rsp_q.size() > 0; i++) begin
      r = rsp_q.pop_front();
      chk($sformatf("rr4_%0d_id", i), r.id, i);
      chk($sformatf("rr4_%0d_pos", i), r.pos, exp_pos[i]);
    end

    // Backpressure: hold response 5 cycles with another requester waiting.
    rsp_q.delete();
    rsp_ready = 1'b0;
    req_data[0 +: 24] = 24'h000100; req_data[24 +: 24] = 24'h000003;
    req_valid[0] = 1'b1;
    step();
    req_valid[1] = 1'b1;
    b = 0;
    while (!o_rsp_valid && b < 10) begin step(); b++; end
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", o_rsp_valid, 1);
      chk("hold_pos", o_rsp_position, 8);
      chk("hold_id", o_rsp_id, 0);
      chk("hold_ready", o_req_ready, 0);
      chk("hold_req1_pending", req_valid[1], 1);
    end
    rsp_ready = 1'b1;
    wait_rsps(2, 20, "hold");
    if (rsp_q.size() >= 2) begin
      r = rsp_q.pop_front();
      chk("hold_rsp0_id", r.id, 0); chk("hold_rsp0_pos", r.pos, 8);
      r = rsp_q.pop_front();
      chk("hold_rsp1_id", r.id, 1); chk("hold_rsp1_pos", r.pos, 1);
    end

    // Reset during CALC discards the operand.
    rsp_q.delete();
    req_data[48 +: 24] = 24'h400000; req_valid[2] = 1'b1;
    step();
    chk("calc_busy", o_busy, 1);
    chk("calc_rsp_valid", o_rsp_valid, 0);
    rst_n = 1'b0;
    #1;
    chk("calc_rst_outputs", {o_req_ready, o_rsp_valid, o_busy, o_rsp_id, o_rsp_position, o_rsp_zero}, 0);
    repeat (2) @(posedge i_clk);
    #1 rst_n = 1'b1;
    repeat (5) step();
    chk("calc_rst_no_rsp", rsp_q.size(), 0);
    req_data[0 +: 24] = 24'h000020; req_valid[0] = 1'b1; req_valid[2] = 1'b1;
    wait_rsps(2, 20, "post_rst");
    if (rsp_q.size() >= 2) begin
      r = rsp_q.pop_front();
      chk("post_rst0_id", r.id, 0); chk("post_rst0_pos", r.pos, 5);
      r = rsp_q.pop_front();
      chk("post_rst1_id", r.id, 2); chk("post_rst1_pos", r.pos, 22);
    end

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
